// File: rtl/pausible_clock_pkg.sv
// rtl/pausible_clock_pkg.sv - shared state type and default sizing for the pausible clock requester
package pausible_clock_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARB  = 2'd1,
    ST_XFER = 2'd2,
    ST_REL  = 2'd3
  } state_t;

  localparam int DEF_WIDTH       = 8;
  localparam int DEF_DEPTH       = 2;
  localparam int DEF_SYNC_STAGES = 2;

endpackage

// File: rtl/sync_ff.sv
// rtl/sync_ff.sv - multi-flop synchronizer for one asynchronous bit
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_q <= '0;
    end else begin
      r_q <= {r_q[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_q[STAGES-1];

endmodule

// File: rtl/pausible_clock_requester.sv
// rtl/pausible_clock_requester.sv - captures 4-phase async words under the clock-generator mutex
// and streams them out through a small FIFO.
module pausible_clock_requester
  import pausible_clock_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int DEPTH       = DEF_DEPTH
) (
  input  logic             clock,
  input  logic             rst,
  output logic             req,
  input  logic             grant,
  input  logic             in_req,
  output logic             in_ack,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic             busy
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  state_t           r_state;
  logic             r_req;
  logic             r_in_ack;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;

  logic w_in_req_s;
  logic w_grant_s;
  logic w_empty;
  logic w_full;
  logic w_pop;

  sync_ff #(.STAGES(SYNC_STAGES)) u_sync_in_req (
    .i_clk (clock),
    .i_rst (rst),
    .i_d   (in_req),
    .o_q   (w_in_req_s)
  );

  sync_ff #(.STAGES(SYNC_STAGES)) u_sync_grant (
    .i_clk (clock),
    .i_rst (rst),
    .i_d   (grant),
    .o_q   (w_grant_s)
  );

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop   = !w_empty && out_ready;

  // in_data is sampled only on the ARB->XFER edge; bundling keeps it stable while in_req is high.
  always_ff @(posedge clock) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_req    <= 1'b0;
      r_in_ack <= 1'b0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_in_req_s && !w_full) begin
            r_req   <= 1'b1;
            r_state <= ST_ARB;
          end
        end
        ST_ARB: begin
          if (w_grant_s) begin
            r_mem[r_wr_ptr[AW-1:0]] <= in_data;
            r_wr_ptr                <= r_wr_ptr + PTR_ONE;
            r_in_ack                <= 1'b1;
            r_state                 <= ST_XFER;
          end
        end
        ST_XFER: begin
          r_req   <= 1'b0;
          r_state <= ST_REL;
        end
        ST_REL: begin
          if (!w_in_req_s && !w_grant_s) begin
            r_in_ack <= 1'b0;
            r_state  <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign req       = r_req;
  assign in_ack    = r_in_ack;
  assign busy      = (r_state != ST_IDLE);
  assign out_valid = !w_empty;
  assign out_data  = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

endmodule
